// File: rtl/daric_xbar_pkg.sv
// rtl/daric_xbar_pkg.sv - shared constants, helper and response-tag type for the scratchpad crossbar
package daric_xbar_pkg;

    localparam int CONF_CNT_W = 16;
    // Tag LSU field is fixed-width so the struct can live in the package; covers up to 256 LSUs.
    localparam int LSU_IDX_W  = 8;

    function automatic int bsel_w(input int num_bank);
        return $clog2(num_bank);
    endfunction

    typedef struct packed {
        logic                 valid;
        logic [LSU_IDX_W-1:0] lsu;
    } rsp_tag_t;

endpackage

// File: rtl/daric_rr_arbiter.sv
// rtl/daric_rr_arbiter.sv - round-robin arbiter, first requester at or after ptr wins
//   req : request vector
//   ptr : highest-priority index this cycle
//   en  : grant enable; no grant when low
//   gnt : one-hot grant (all zero when no request or en low)
module daric_rr_arbiter #(
    parameter  int N     = 4,
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    input  logic             en,
    output logic [N-1:0]     gnt
);

    logic w_found;

    // Two passes: indices at/above ptr first, then the wrapped ones below ptr.
    always_comb begin
        gnt     = '0;
        w_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (en && !w_found && req[i] && (i >= int'(ptr))) begin
                gnt[i]  = 1'b1;
                w_found = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (en && !w_found && req[i] && (i < int'(ptr))) begin
                gnt[i]  = 1'b1;
                w_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/daric_spm_xbar.sv
// rtl/daric_spm_xbar.sv - arbitrated LSU-to-scratchpad-bank crossbar with registered read responses
//   clk, rst      : clock, synchronous active-high reset
//   run           : gates all grants
//   lsu_req_*     : per-LSU request (valid/we/addr/wdata), ready is the combinational grant
//   lsu_rsp_*     : per-LSU read response, valid one cycle after the grant
//   bank_*        : per-bank access (en/we/row addr/wdata), bank_rdata valid cycle after en
//   conflict_cnt  : per-bank saturating loser count, only with DARIC_XBAR_CONFLICT_CNT_EN
module daric_spm_xbar
    import daric_xbar_pkg::*;
#(
    parameter int NUM_LSU  = 4,
    parameter int NUM_BANK = 4,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 10
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   run,
    input  logic [NUM_LSU-1:0]                     lsu_req_valid,
    input  logic [NUM_LSU-1:0]                     lsu_req_we,
    input  logic [NUM_LSU*ADDR_W-1:0]              lsu_req_addr,
    input  logic [NUM_LSU*DATA_W-1:0]              lsu_req_wdata,
    output logic [NUM_LSU-1:0]                     lsu_req_ready,
    output logic [NUM_LSU-1:0]                     lsu_rsp_valid,
    output logic [NUM_LSU*DATA_W-1:0]              lsu_rsp_data,
    output logic [NUM_BANK-1:0]                    bank_en,
    output logic [NUM_BANK-1:0]                    bank_we,
    output logic [NUM_BANK*(ADDR_W-bsel_w(NUM_BANK))-1:0] bank_addr,
    output logic [NUM_BANK*DATA_W-1:0]             bank_wdata,
    input  logic [NUM_BANK*DATA_W-1:0]             bank_rdata
`ifdef DARIC_XBAR_CONFLICT_CNT_EN
    ,
    output logic [NUM_BANK*CONF_CNT_W-1:0]         conflict_cnt
`endif
);

    localparam int BSEL_W = bsel_w(NUM_BANK);
    localparam int ROW_W  = ADDR_W - BSEL_W;
    localparam int LIDX_W = (NUM_LSU > 1) ? $clog2(NUM_LSU) : 1;

    logic [NUM_LSU-1:0] w_req [NUM_BANK];
    logic [NUM_LSU-1:0] w_gnt [NUM_BANK];
    logic [LIDX_W-1:0]  w_win_idx [NUM_BANK];
    logic               w_arb_en;

    logic [LIDX_W-1:0]  r_ptr [NUM_BANK];
    rsp_tag_t           r_tag [NUM_BANK];
    logic [DATA_W-1:0]  r_rsp_data [NUM_LSU];

    // Reset also blocks grants so nothing is issued to the banks while state is clearing.
    assign w_arb_en = run && !rst;

    always_comb begin
        for (int b = 0; b < NUM_BANK; b++) begin
            for (int i = 0; i < NUM_LSU; i++) begin
                w_req[b][i] = lsu_req_valid[i] &&
                              (lsu_req_addr[i*ADDR_W +: BSEL_W] == BSEL_W'(b));
            end
        end
    end

    for (genvar gb = 0; gb < NUM_BANK; gb++) begin : g_bank
        daric_rr_arbiter #(.N(NUM_LSU)) u_arb (
            .req (w_req[gb]),
            .ptr (r_ptr[gb]),
            .en  (w_arb_en),
            .gnt (w_gnt[gb])
        );
    end

    // Grants are one-hot per bank, so the loop leaves at most one winner's fields.
    always_comb begin
        bank_en       = '0;
        bank_we       = '0;
        bank_addr     = '0;
        bank_wdata    = '0;
        lsu_req_ready = '0;
        for (int b = 0; b < NUM_BANK; b++) begin
            w_win_idx[b] = '0;
            for (int i = 0; i < NUM_LSU; i++) begin
                if (w_gnt[b][i]) begin
                    bank_en[b]                       = 1'b1;
                    bank_we[b]                       = lsu_req_we[i];
                    bank_addr[b*ROW_W +: ROW_W]      = lsu_req_addr[i*ADDR_W+BSEL_W +: ROW_W];
                    bank_wdata[b*DATA_W +: DATA_W]   = lsu_req_wdata[i*DATA_W +: DATA_W];
                    lsu_req_ready[i]                 = 1'b1;
                    w_win_idx[b]                     = LIDX_W'(i);
                end
            end
        end
    end

    // A tag raised before reset must not surface, hence the rst term.
    always_comb begin
        lsu_rsp_valid = '0;
        lsu_rsp_data  = '0;
        for (int i = 0; i < NUM_LSU; i++) begin
            lsu_rsp_data[i*DATA_W +: DATA_W] = r_rsp_data[i];
            for (int b = 0; b < NUM_BANK; b++) begin
                if (!rst && r_tag[b].valid && (r_tag[b].lsu == LSU_IDX_W'(i))) begin
                    lsu_rsp_valid[i]                 = 1'b1;
                    lsu_rsp_data[i*DATA_W +: DATA_W] = bank_rdata[b*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < NUM_BANK; b++) begin
                r_ptr[b] <= '0;
                r_tag[b] <= '0;
            end
            for (int i = 0; i < NUM_LSU; i++) begin
                r_rsp_data[i] <= '0;
            end
        end else begin
            for (int b = 0; b < NUM_BANK; b++) begin
                if (bank_en[b]) begin
                    r_ptr[b] <= (w_win_idx[b] == LIDX_W'(NUM_LSU-1)) ? '0 : w_win_idx[b] + 1'b1;
                end
                r_tag[b].valid <= bank_en[b] && !bank_we[b];
                r_tag[b].lsu   <= LSU_IDX_W'(w_win_idx[b]);
            end
            for (int i = 0; i < NUM_LSU; i++) begin
                if (lsu_rsp_valid[i]) begin
                    r_rsp_data[i] <= lsu_rsp_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

`ifdef DARIC_XBAR_CONFLICT_CNT_EN
    localparam int SUM_W = CONF_CNT_W + 1;

    logic [CONF_CNT_W-1:0] r_conf_cnt [NUM_BANK];
    logic [CONF_CNT_W-1:0] w_conf_nxt [NUM_BANK];
    logic [SUM_W-1:0]      w_conf_sum [NUM_BANK];

    // Losers = requesters - 1 whenever run is high, since a winner always exists then.
    always_comb begin
        for (int b = 0; b < NUM_BANK; b++) begin
            w_conf_sum[b] = {1'b0, r_conf_cnt[b]};
            w_conf_nxt[b] = r_conf_cnt[b];
            if (run && ($countones(w_req[b]) > 1)) begin
                w_conf_sum[b] = {1'b0, r_conf_cnt[b]} + SUM_W'($countones(w_req[b]) - 1);
                w_conf_nxt[b] = w_conf_sum[b][CONF_CNT_W] ? '1 : w_conf_sum[b][CONF_CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < NUM_BANK; b++) begin
                r_conf_cnt[b] <= '0;
            end
        end else begin
            for (int b = 0; b < NUM_BANK; b++) begin
                r_conf_cnt[b] <= w_conf_nxt[b];
            end
        end
    end

    for (genvar gc = 0; gc < NUM_BANK; gc++) begin : g_conf
        assign conflict_cnt[gc*CONF_CNT_W +: CONF_CNT_W] = r_conf_cnt[gc];
    end
`endif

endmodule

// File: tb/tb_daric_spm_xbar.sv
// tb/tb_daric_spm_xbar.sv - self-checking bench for daric_spm_xbar
module tb_daric_spm_xbar;

    localparam int NL = 4;
    localparam int NB = 4;
    localparam int DW = 32;
    localparam int AW = 10;
    localparam int RW = 8;
    localparam int NROW = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic run = 1'b0;
    logic [NL-1:0]    req_v = '0;
    logic [NL-1:0]    req_we = '0;
    logic [NL*AW-1:0] req_addr = '0;
    logic [NL*DW-1:0] req_wdata = '0;
    logic [NL-1:0]    req_ready;
    logic [NL-1:0]    rsp_valid;
    logic [NL*DW-1:0] rsp_data;
    logic [NB-1:0]    bank_en;
    logic [NB-1:0]    bank_we;
    logic [NB*RW-1:0] bank_addr;
    logic [NB*DW-1:0] bank_wdata;
    logic [NB*DW-1:0] bank_rdata = '0;
`ifdef DARIC_XBAR_CONFLICT_CNT_EN
    logic [NB*16-1:0] conflict_cnt;
`endif

    daric_spm_xbar #(.NUM_LSU(NL), .NUM_BANK(NB), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .run           (run),
        .lsu_req_valid (req_v),
        .lsu_req_we    (req_we),
        .lsu_req_addr  (req_addr),
        .lsu_req_wdata (req_wdata),
        .lsu_req_ready (req_ready),
        .lsu_rsp_valid (rsp_valid),
        .lsu_rsp_data  (rsp_data),
        .bank_en       (bank_en),
        .bank_we       (bank_we),
        .bank_addr     (bank_addr),
        .bank_wdata    (bank_wdata),
        .bank_rdata    (bank_rdata)
`ifdef DARIC_XBAR_CONFLICT_CNT_EN
        ,
        .conflict_cnt  (conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model state: per-bank pointer, per-LSU pending read, shadow memory.
    int          mptr [NB];
    bit          mpend_v [NL];
    logic [31:0] mpend_d [NL];
    logic [31:0] mlast [NL];
    logic [31:0] exp_mem [NB][NROW];
    int          mconf [NB];

    // Bench-side banks, driven only from what the DUT actually put on the bank ports.
    logic [31:0]      fx_mem [NB][NROW];
    logic [NB-1:0]    fx_en = '0;
    logic [NB-1:0]    fx_we = '0;
    logic [NB*RW-1:0] fx_addr = '0;
    logic [NB*DW-1:0] fx_wdata = '0;

    always @(negedge clk) begin : p_cmp
        logic [NL-1:0]    e_ready;
        logic [NB-1:0]    e_en;
        logic [NB-1:0]    e_we;
        logic [NB*RW-1:0] e_addr;
        logic [NB*DW-1:0] e_wd;
        logic [NL-1:0]    e_rv;
        logic [NL*DW-1:0] e_rd;
        int               win [NB];
        int               nreq [NB];
        int               row;

        e_ready = '0; e_en = '0; e_we = '0; e_addr = '0; e_wd = '0; e_rv = '0; e_rd = '0;
        for (int b = 0; b < NB; b++) begin
            win[b]  = -1;
            nreq[b] = 0;
            for (int i = 0; i < NL; i++)
                if (req_v[i] && int'(req_addr[i*AW +: 2]) == b) nreq[b]++;
            if (run && !rst) begin
                for (int k = 0; k < NL; k++) begin
                    int i;
                    i = (mptr[b] + k) % NL;
                    if (win[b] < 0 && req_v[i] && int'(req_addr[i*AW +: 2]) == b) win[b] = i;
                end
            end
            if (win[b] >= 0) begin
                e_en[b]              = 1'b1;
                e_we[b]              = req_we[win[b]];
                e_addr[b*RW +: RW]   = req_addr[win[b]*AW+2 +: RW];
                e_wd[b*DW +: DW]     = req_wdata[win[b]*DW +: DW];
                e_ready[win[b]]      = 1'b1;
            end
        end
        for (int i = 0; i < NL; i++) begin
            e_rv[i]          = mpend_v[i] && !rst;
            e_rd[i*DW +: DW] = e_rv[i] ? mpend_d[i] : mlast[i];
        end

        check("ready",      256'(req_ready),  256'(e_ready));
        check("bank_en",    256'(bank_en),    256'(e_en));
        check("bank_we",    256'(bank_we),    256'(e_we));
        check("bank_addr",  256'(bank_addr),  256'(e_addr));
        check("bank_wdata", 256'(bank_wdata), 256'(e_wd));
        check("rsp_valid",  256'(rsp_valid),  256'(e_rv));
        check("rsp_data",   256'(rsp_data),   256'(e_rd));
`ifdef DARIC_XBAR_CONFLICT_CNT_EN
        for (int b = 0; b < NB; b++)
            check("conflict_cnt", 256'(conflict_cnt[b*16 +: 16]), 256'(mconf[b]));
`endif

        if (rst) begin
            for (int b = 0; b < NB; b++) begin mptr[b] = 0; mconf[b] = 0; end
            for (int i = 0; i < NL; i++) begin mpend_v[i] = 0; mlast[i] = '0; end
        end else begin
            for (int i = 0; i < NL; i++) begin
                if (e_rv[i]) mlast[i] = mpend_d[i];
                mpend_v[i] = 0;
            end
            for (int b = 0; b < NB; b++) begin
                if (run && nreq[b] > 1)
                    mconf[b] = (mconf[b] + nreq[b] - 1 > 65535) ? 65535 : mconf[b] + nreq[b] - 1;
                if (win[b] >= 0) begin
                    mptr[b] = (win[b] + 1) % NL;
                    row = int'(req_addr[win[b]*AW+2 +: RW]);
                    if (req_we[win[b]]) begin
                        exp_mem[b][row] = req_wdata[win[b]*DW +: DW];
                    end else begin
                        mpend_v[win[b]] = 1;
                        mpend_d[win[b]] = exp_mem[b][row];
                    end
                end
            end
        end

        fx_en    = bank_en;
        fx_we    = bank_we;
        fx_addr  = bank_addr;
        fx_wdata = bank_wdata;
    end

    task automatic step();
        @(posedge clk);
        #1;
        for (int b = 0; b < NB; b++) begin
            if (fx_en[b]) begin
                if (fx_we[b]) fx_mem[b][fx_addr[b*RW +: RW]] = fx_wdata[b*DW +: DW];
                else          bank_rdata[b*DW +: DW] = fx_mem[b][fx_addr[b*RW +: RW]];
            end
        end
    endtask

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [31:0] d);
        req_v[i]             = 1'b1;
        req_we[i]            = we;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic clear_req();
        req_v = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    endtask

    logic [NL-1:0] rr_exp [5];

    initial begin
        for (int b = 0; b < NB; b++) begin
            mptr[b] = 0; mconf[b] = 0;
            for (int r = 0; r < NROW; r++) begin
                exp_mem[b][r] = {8'hA0 + 8'(b), 8'(r), 16'h5A5A};
                fx_mem[b][r]  = {8'hA0 + 8'(b), 8'(r), 16'h5A5A};
            end
        end
        exp_mem[1][1] = 32'hDEADBEEF;
        fx_mem[1][1]  = 32'hDEADBEEF;
        for (int i = 0; i < NL; i++) begin mpend_v[i] = 0; mpend_d[i] = '0; mlast[i] = '0; end
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;

        // Reset state
        rst = 1'b1; run = 1'b0;
        step(); step();
        @(negedge clk);
        check("reset_rsp_valid", 256'(rsp_valid), 256'(0));
        check("reset_rsp_data",  256'(rsp_data),  256'(0));
        rst = 1'b0; run = 1'b1;
        step();

        // Single read of 0x005: bank 1, row 1
        set_req(0, 1'b0, 10'h005, 32'h0);
        @(negedge clk);
        check("single_ready",   256'(req_ready),         256'(4'b0001));
        check("single_bank_en", 256'(bank_en),           256'(4'b0010));
        check("single_row",     256'(bank_addr[RW +: RW]), 256'(1));
        step(); clear_req();
        @(negedge clk);
        check("single_rsp_valid", 256'(rsp_valid),     256'(4'b0001));
        check("single_rsp_data",  256'(rsp_data[31:0]), 256'(32'hDEADBEEF));

        // Four LSUs contend for bank 2 for five cycles
        step();
        for (int i = 0; i < NL; i++) set_req(i, 1'b0, AW'(4*i + 2), 32'h0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("rr_grant", 256'(req_ready), 256'(rr_exp[c]));
            step();
        end
        clear_req();
`ifdef DARIC_XBAR_CONFLICT_CNT_EN
        @(negedge clk);
        check("conflict_bank2", 256'(conflict_cnt[2*16 +: 16]), 256'(15));
`endif
        step();

        // All four banks in parallel
        for (int i = 0; i < NL; i++) set_req(i, 1'b0, AW'(12 + i), 32'h0);
        @(negedge clk);
        check("parallel_ready", 256'(req_ready), 256'(4'hF));
        step(); clear_req();
        @(negedge clk);
        check("parallel_rsp_valid", 256'(rsp_valid), 256'(4'hF));
        step();

        // Move bank 3 pointer to 2, then hold requests with run low
        set_req(1, 1'b0, 10'h007, 32'h0);
        step(); clear_req();
        run = 1'b0;
        for (int i = 0; i < NL; i++) set_req(i, 1'b0, AW'(4*i + 3), 32'h0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("run_low_ready", 256'(req_ready), 256'(0));
            step();
        end
        run = 1'b1;
        @(negedge clk);
        check("run_resume_ready", 256'(req_ready), 256'(4'b0100));
        step(); clear_req();
        step();

        // Reset while a read is in flight
        set_req(2, 1'b0, 10'h000, 32'h0);
        @(negedge clk);
        check("inflight_ready", 256'(req_ready), 256'(4'b0100));
        step(); clear_req();
        rst = 1'b1;
        @(negedge clk);
        check("inflight_dropped", 256'(rsp_valid), 256'(0));
        step();
        rst = 1'b0;
        for (int i = 0; i < NL; i++) set_req(i, 1'b0, AW'(4*i), 32'h0);
        @(negedge clk);
        check("post_reset_rsp",  256'(rsp_valid), 256'(0));
        check("post_reset_ptr",  256'(req_ready), 256'(4'b0001));
        step(); clear_req();
        step();

        // Write then read back from another LSU
        set_req(1, 1'b1, 10'h00C, 32'h12345678);
        @(negedge clk);
        check("write_bank_we",    256'(bank_we),          256'(4'b0001));
        check("write_bank_wdata", 256'(bank_wdata[31:0]), 256'(32'h12345678));
        step(); clear_req();
        set_req(3, 1'b0, 10'h00C, 32'h0);
        step(); clear_req();
        @(negedge clk);
        check("readback_valid", 256'(rsp_valid),        256'(4'b1000));
        check("readback_data",  256'(rsp_data[127:96]), 256'(32'h12345678));
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
